// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Used by mem_port_arbiter and arb_starve_ctr.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF       = 32;
   localparam int unsigned DATA_W_DEF       = 32;
   localparam int unsigned STARVE_LIMIT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RESP
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } owner_t;

   // Data normally wins because it belongs to the older instruction.
   // force_if lets a starved fetch through when both requesters are present.
   function automatic owner_t pick_owner(input logic if_req,
                                         input logic d_req,
                                         input logic force_if);
      if (d_req && !(force_if && if_req))
         return OWN_D;
      else
         return OWN_IF;
   endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data wins over a waiting fetch.
// force_if goes high once the count reaches STARVE_LIMIT.
module arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   arb_en,
   input  owner_t win_owner,
   input  logic   if_req,
   output logic   force_if
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear on a fetch win, bump (saturating) on a data win over a waiting fetch
   always_comb begin
      cnt_d = cnt_q;
      if (arb_en) begin
         if (win_owner == OWN_IF)
            cnt_d = '0;
         else if (if_req && (cnt_q != LIMIT))
            cnt_d = cnt_q + 1'b1;
      end
      force_if = (cnt_q == LIMIT);
   end

   // Counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// One transaction outstanding; response routed back to the latched owner.
// Optional fetch starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = ADDR_W_DEF,
   parameter int unsigned DATA_WIDTH   = DATA_W_DEF,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  stall
);

   state_t                state_q, state_d;
   owner_t                owner_q, owner_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic   force_if;
   owner_t sel_owner;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic arb_en;

   assign arb_en = (state_q == IDLE) && (if_req || d_req);

   arb_starve_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk       (clk),
      .rst       (rst),
      .arb_en    (arb_en),
      .win_owner (sel_owner),
      .if_req    (if_req),
      .force_if  (force_if)
   );
`else
   assign force_if = 1'b0;
`endif

   assign sel_owner = pick_owner(if_req, d_req, force_if);

   // Next state and latched transaction fields; fields are sampled only in IDLE
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               state_d = WAIT_GNT;
               owner_d = sel_owner;
               if (sel_owner == OWN_D) begin
                  we_d    = d_we;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = if_addr;
                  wdata_d = '0;
               end
            end
         end
         WAIT_GNT: begin
            if (mem_gnt)
               state_d = WAIT_RESP;
         end
         WAIT_RESP: begin
            if (mem_rvalid)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory-side drive, owner handshake routing and core stall
   always_comb begin
      mem_req   = (state_q == WAIT_GNT);
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if_gnt    = mem_req && mem_gnt && (owner_q == OWN_IF);
      d_gnt     = mem_req && mem_gnt && (owner_q == OWN_D);
      if_rvalid = (state_q == WAIT_RESP) && mem_rvalid && (owner_q == OWN_IF);
      d_rvalid  = (state_q == WAIT_RESP) && mem_rvalid && (owner_q == OWN_D);
      if_rdata  = mem_rdata;
      d_rdata   = mem_rdata;
      stall     = (if_req && !if_rvalid) ||
                  (d_req && !d_rvalid) ||
                  ((state_q != IDLE) && !mem_rvalid);
   end

   // State and transaction registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= OWN_IF;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model,
// bench-side memory slave, golden memory and directed latency scenarios.
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk, rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall;

   mem_port_arbiter #(
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_req     (if_req),
      .if_addr    (if_addr),
      .if_gnt     (if_gnt),
      .if_rvalid  (if_rvalid),
      .if_rdata   (if_rdata),
      .d_req      (d_req),
      .d_we       (d_we),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_gnt      (d_gnt),
      .d_rvalid   (d_rvalid),
      .d_rdata    (d_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .stall      (stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int idx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   // Golden memory (requester view) and slave memory (what the DUT wrote)
   logic [31:0] gold [256];
   logic [31:0] smem [256];

   // Reference model: one outstanding transaction
   bit          m_busy, m_gnted, m_own_d, m_we, dwin;
   logic [31:0] m_addr, m_wdata;
   int          m_cnt;
   bit          e_mem_req, e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_stall;

   // Requesters: 0 idle, 1 requesting, 2 awaiting response
   int          if_st, d_st, if_mode, d_mode;
   bit          if_fix, d_fix, d_fix_we, start;
   logic [31:0] if_fix_addr, d_fix_addr, d_fix_wdata;

   // Memory slave
   bit          s_pend, s_req_seen, s_cap_we, spur_force, go;
   logic [31:0] s_cap_addr, s_cap_wdata, s_addr;
   int          s_cnt, gd, rd;

   // DUT snapshots taken at the compare point
   logic        o_mem_req, o_if_gnt, o_d_gnt, o_if_rv, o_d_rv, o_stall, o_we;
   logic [31:0] o_addr, o_wdata, o_if_rdata, o_d_rdata;

   task automatic model_reset();
      m_busy = 0; m_gnted = 0; m_own_d = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_cnt = 0;
      if_st = 0; d_st = 0;
   endtask

   task automatic update_all();
      if (!rst) begin
         model_reset();
      end else begin
         if (e_d_gnt && m_we) gold[idx(m_addr)] = m_wdata;
         if (if_st == 1 && e_if_gnt) if_st = 2;
         else if (if_st == 2 && e_if_rv) if_st = 0;
         if (d_st == 1 && e_d_gnt) d_st = 2;
         else if (d_st == 2 && e_d_rv) d_st = 0;
         if (!m_busy) begin
            if (if_req || d_req) begin
               dwin = d_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
               if (d_req && if_req && m_cnt == LIMIT) dwin = 0;
`endif
               m_busy = 1; m_gnted = 0; m_own_d = dwin;
               if (dwin) begin
                  m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                  if (if_req && m_cnt < LIMIT) m_cnt++;
               end else begin
                  m_we = 0; m_addr = if_addr; m_wdata = '0;
                  m_cnt = 0;
               end
            end
         end else if (!m_gnted) begin
            if (mem_gnt) m_gnted = 1;
         end else if (mem_rvalid) begin
            m_busy = 0;
         end
      end
      if (!s_pend) begin
         if (mem_gnt) begin
            if (s_cap_we) smem[idx(s_cap_addr)] = s_cap_wdata;
            s_addr = s_cap_addr; s_pend = 1; s_cnt = 0;
         end else if (s_req_seen) s_cnt++;
         else s_cnt = 0;
      end else if (mem_rvalid) begin
         s_pend = 0; s_cnt = 0;
      end else begin
         s_cnt++;
      end
   endtask

   task automatic drive_all();
      if (if_st == 0 && rst) begin
         start = (if_mode == 1) ? ($urandom_range(0, 2) == 0) : (if_mode >= 2);
         if (start) begin
            if_st = 1;
            if_addr = if_fix ? if_fix_addr : ($urandom & 32'hFFFF_FFFC);
            if (if_mode == 3) if_mode = 0;
         end
      end
      if (if_st != 1) if_addr = $urandom;
      if_req = (if_st == 1);

      if (d_st == 0 && rst) begin
         start = (d_mode == 1) ? ($urandom_range(0, 2) == 0) : (d_mode >= 2);
         if (start) begin
            d_st = 1;
            d_we    = d_fix ? d_fix_we    : 1'($urandom_range(0, 1));
            d_addr  = d_fix ? d_fix_addr  : ($urandom & 32'hFFFF_FFFC);
            d_wdata = d_fix ? d_fix_wdata : $urandom;
            if (d_mode == 3) d_mode = 0;
         end
      end
      if (d_st != 1) begin
         d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
      d_req = (d_st == 1);

      mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
      s_req_seen = mem_req;
      if (!s_pend) begin
         if (mem_req) begin
            go = (gd < 0) ? ($urandom_range(0, 1) == 1) : (s_cnt >= gd);
            if (go) begin
               mem_gnt = 1;
               s_cap_we = mem_we; s_cap_addr = mem_addr; s_cap_wdata = mem_wdata;
            end
         end
         if (spur_force || (gd < 0 && $urandom_range(0, 3) == 0)) mem_rvalid = 1;
      end else begin
         go = (rd < 0) ? ($urandom_range(0, 2) == 0) : (s_cnt >= rd);
         if (go) begin
            mem_rvalid = 1;
            mem_rdata = smem[idx(s_addr)];
         end
      end
   endtask

   task automatic compare();
      e_mem_req = m_busy && !m_gnted;
      e_if_gnt  = e_mem_req && mem_gnt && !m_own_d;
      e_d_gnt   = e_mem_req && mem_gnt && m_own_d;
      e_if_rv   = m_busy && m_gnted && mem_rvalid && !m_own_d;
      e_d_rv    = m_busy && m_gnted && mem_rvalid && m_own_d;
      e_stall   = (if_req && !e_if_rv) || (d_req && !e_d_rv) || (m_busy && !mem_rvalid);
      o_mem_req = mem_req; o_if_gnt = if_gnt; o_d_gnt = d_gnt;
      o_if_rv = if_rvalid; o_d_rv = d_rvalid; o_stall = stall;
      o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
      o_if_rdata = if_rdata; o_d_rdata = d_rdata;
      chk("mem_req", o_mem_req, e_mem_req);
      chk("if_gnt", o_if_gnt, e_if_gnt);
      chk("d_gnt", o_d_gnt, e_d_gnt);
      chk("if_rvalid", o_if_rv, e_if_rv);
      chk("d_rvalid", o_d_rv, e_d_rv);
      chk("stall", o_stall, e_stall);
      if (e_mem_req) begin
         chk("mem_we", o_we, m_we);
         chk("mem_addr", o_addr, m_addr);
         if (m_we) chk("mem_wdata", o_wdata, m_wdata);
      end
      if (e_if_rv) chk("if_rdata", o_if_rdata, gold[idx(m_addr)]);
      if (e_d_rv && !m_we) chk("d_rdata", o_d_rdata, gold[idx(m_addr)]);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      update_all();
      #1;
      drive_all();
      #3;
      compare();
   endtask

   task automatic drain();
      if_mode = 0; d_mode = 0;
      for (int i = 0; i < 300; i++) begin
         if (!m_busy && if_st == 0 && d_st == 0 && !s_pend) break;
         step();
      end
      chk("drain_idle", {63'd0, (!m_busy && if_st == 0 && d_st == 0 && !s_pend)}, 64'd1);
   endtask

   int          n, ngnt, d_rv_c, if_rv_c, req_n, stall_n, rv_c, arb, if_win;
   bit          first_d, second_if, stable;
   logic        f_we;
   logic [31:0] f_addr, f_wdata;

   initial begin
      rst = 0;
      if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
      if_mode = 0; d_mode = 0; if_fix = 0; d_fix = 0; spur_force = 0;
      gd = 0; rd = 0; s_pend = 0; s_cnt = 0; s_req_seen = 0;
      model_reset();
      for (int i = 0; i < 256; i++) begin
         gold[i] = $urandom;
         smem[i] = gold[i];
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_gnt", {if_gnt, d_gnt}, 0);
      chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
      chk("rst_stall", stall, 0);
      @(negedge clk);
      rst = 1;

      // Lone fetch, zero-wait memory
      gold[4] = 32'h0010_0513; smem[4] = 32'h0010_0513;
      if_fix = 1; if_fix_addr = 32'h0000_0010; if_mode = 3;
      step(); n = cyc;
      chk("lf_mem_req_N", o_mem_req, 0);
      chk("lf_stall_N", o_stall, 1);
      step();
      chk("lf_mem_req_N1", o_mem_req, 1);
      chk("lf_if_gnt_N1", o_if_gnt, 1);
      chk("lf_mem_addr_N1", o_addr, 32'h10);
      step();
      chk("lf_if_rvalid_N2", o_if_rv, 1);
      chk("lf_if_rdata_N2", o_if_rdata, 32'h0010_0513);
      chk("lf_stall_N2", o_stall, 0);
      step();
      chk("lf_mem_req_N3", o_mem_req, 0);
      drain();

      // Store and fetch requested together
      d_fix = 1; d_fix_we = 1; d_fix_addr = 32'h100; d_fix_wdata = 32'hDEAD_BEEF;
      if_fix_addr = 32'h20; if_mode = 3; d_mode = 3;
      ngnt = 0; d_rv_c = -1; if_rv_c = -1; first_d = 0; second_if = 0;
      f_we = 0; f_addr = '0; f_wdata = '0;
      n = cyc + 1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (o_d_gnt || o_if_gnt) begin
            ngnt++;
            if (ngnt == 1) begin
               first_d = o_d_gnt; f_we = o_we; f_addr = o_addr; f_wdata = o_wdata;
            end
            if (ngnt == 2) second_if = o_if_gnt;
         end
         if (o_d_rv && d_rv_c < 0) d_rv_c = cyc;
         if (o_if_rv && if_rv_c < 0) if_rv_c = cyc;
      end
      chk("sf_first_is_data", first_d, 1);
      chk("sf_first_we", f_we, 1);
      chk("sf_first_addr", f_addr, 32'h100);
      chk("sf_first_wdata", f_wdata, 32'hDEAD_BEEF);
      chk("sf_second_is_fetch", second_if, 1);
      chk("sf_d_rvalid_cycle", d_rv_c, n + 2);
      chk("sf_if_rvalid_cycle", if_rv_c, n + 5);
      drain();
      d_fix_we = 0; d_mode = 3; rv_c = -1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (o_d_rv && rv_c < 0) begin
            rv_c = cyc;
            chk("sf_load_back", o_d_rdata, 32'hDEAD_BEEF);
         end
      end
      chk("sf_load_seen", {63'd0, (rv_c >= 0)}, 64'd1);
      d_fix = 0;
      drain();

      // Wait states: grant after 3 idle request cycles, response 2 cycles later
      gd = 3; rd = 2; if_fix_addr = 32'h44; if_mode = 3;
      step(); n = cyc;
      req_n = 0; stall_n = o_stall ? 1 : 0; rv_c = -1; stable = 1; f_addr = '0; f_we = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (o_if_rv) begin
            rv_c = cyc;
            chk("ws_stall_at_rvalid", o_stall, 0);
            break;
         end
         if (o_stall) stall_n++;
         if (o_mem_req) begin
            if (req_n == 0) begin f_addr = o_addr; f_we = o_we; end
            else if (o_addr !== f_addr || o_we !== f_we) stable = 0;
            req_n++;
         end
      end
      chk("ws_mem_req_cycles", req_n, 4);
      chk("ws_fields_stable", stable, 1);
      chk("ws_stall_cycles", stall_n, 7);
      chk("ws_rvalid_cycle", rv_c, n + 7);
      if_fix = 0; gd = 0; rd = 0;
      drain();

      // Starvation under continuous data requests
      d_mode = 2; if_mode = 3; arb = 0; if_win = 0;
      for (int i = 0; i < 45; i++) begin
         step();
         if (o_d_gnt || o_if_gnt) arb++;
         if (o_if_gnt && if_win == 0) if_win = arb;
      end
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk("starve_fetch_win_index", if_win, 5);
`else
      chk("starve_fetch_never", if_win, 0);
`endif
      drain();

      // Spurious memory response while idle
      spur_force = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("sp_no_rvalid", {o_if_rv, o_d_rv}, 0);
         chk("sp_no_mem_req", o_mem_req, 0);
      end
      spur_force = 0;
      if_mode = 3;
      step();
      step();
      chk("sp_then_mem_req", o_mem_req, 1);
      drain();

      // Reset during WAIT_RESP, then a late response after release
      rd = 1000; if_mode = 3;
      step(); step(); step();
      chk("rm_in_resp_stall", o_stall, 1);
      #2;
      rst = 0;
      model_reset();
      mem_gnt = 1; mem_rvalid = 1;
      #1;
      chk("rm_mem_req", mem_req, 0);
      chk("rm_gnt", {if_gnt, d_gnt}, 0);
      chk("rm_rvalid", {if_rvalid, d_rvalid}, 0);
      chk("rm_stall", stall, 0);
      mem_gnt = 0; mem_rvalid = 0;
      step(); step();
      #2;
      rst = 1;
      rd = 0;
      step();
      chk("rm_late_rvalid_ignored", {o_if_rv, o_d_rv}, 0);
      chk("rm_late_no_mem_req", o_mem_req, 0);
      drain();

      // Randomized traffic with random memory wait states
      gd = -1; rd = -1; if_mode = 1; d_mode = 1;
      repeat (3000) step();
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one unified single-port memory between the CPU's instruction-fetch path and its load/store data path, so the core can run from a single RAM instead of separate instruction and data memories. It arbitrates between the two requesters, keeps one memory transaction outstanding at a time, and routes the response back to the owner. It drives a `stall` signal so the core's PC and register writes hold until the current instruction's accesses complete.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data word width.
- `STARVE_LIMIT`, 4, consecutive data wins over a waiting fetch before fetch is forced through (guard only).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in ADDR_WIDTH: fetch address (PC).
- `if_gnt` out 1: fetch accepted by memory.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out DATA_WIDTH: instruction word.
- `d_req` in 1: data request; held until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_WIDTH: data address.
- `d_wdata` in DATA_WIDTH: store data.
- `d_gnt` out 1: data request accepted.
- `d_rvalid` out 1: load data / store ack valid.
- `d_rdata` out DATA_WIDTH: load data.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_wdata` out DATA_WIDTH: memory write data.
- `mem_gnt` in 1: memory accepted request this cycle.
- `mem_rvalid` in 1: response valid (both reads and writes).
- `mem_rdata` in DATA_WIDTH: read data.
- `stall` out 1: core must hold.

## Operation
- FSM `IDLE` → `WAIT_GNT` → `WAIT_RESP` → `IDLE`. Only one transaction is outstanding.
- **IDLE:** if any request is present, select an owner and register owner, we, addr, and wdata, then go to `WAIT_GNT`. With no request, stay in `IDLE`.
- **Priority:** data beats fetch, because the data access belongs to the older instruction. A lone requester always wins.
- **WAIT_GNT:** `mem_req`=1 with the registered fields. When `mem_gnt`=1, pulse the owner's `*_gnt` combinationally and go to `WAIT_RESP`.
- **WAIT_RESP:** `mem_req`=0. When `mem_rvalid`=1, assert the owner's `*_rvalid`, pass `mem_rdata` through combinationally, and go to `IDLE`.
- Non-owner `*_gnt` and `*_rvalid` stay 0. `if_rdata` and `d_rdata` equal `mem_rdata` at all times and are meaningful only with their `rvalid`.
- `mem_rvalid` in `IDLE` or `WAIT_GNT` is ignored.
- A requester dropping `req` before its grant is illegal. The latched transaction still completes and still pulses `rvalid` to the owner.
- `stall` = (`if_req` & ~`if_rvalid`) | (`d_req` & ~`d_rvalid`) | (state ≠ `IDLE` & ~`mem_rvalid`).
- Request fields are sampled only in `IDLE`. Changes later are ignored until the next arbitration.

## Timing
- **Reset values:** state `IDLE`, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, all `*_gnt` and `*_rvalid`=0, `stall`=0 with no requests, starve counter 0.
- **Reset mid-transaction:** `mem_req` drops immediately (asynchronous). An in-flight memory response after reset release is ignored.
- **Latency:** request in cycle N → `mem_req` in N+1. With a zero-wait memory, `gnt` arrives in N+1 and `rvalid` in N+2. The FSM returns to `IDLE` in N+3, so a new `mem_req` can start no earlier than N+4.
- **Minimum occupancy** is 3 cycles per transaction. Memory wait states extend `WAIT_GNT` or `WAIT_RESP` indefinitely, and `stall` holds throughout.
- **Simultaneous events:** with `if_req` and `d_req` together in `IDLE`, the priority rule decides. A new request arriving during `WAIT_RESP` is arbitrated in the following `IDLE` cycle.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- **Defined:** a counter of width $clog2(STARVE_LIMIT+1) behaves as follows.
  - It increments, saturating, when data wins in `IDLE` while `if_req`=1.
  - It clears when fetch wins.
  - When it equals `STARVE_LIMIT` and both requesters are present, fetch wins.
- **Undefined:** strict data priority and no counter. Fetch can starve under continuous `d_req`.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum: `IDLE`, `WAIT_GNT`, `WAIT_RESP`.
  - `owner_t` enum: `OWN_IF`, `OWN_D`.
  - Default width localparams.
- Sub-module `arb_starve_ctr` holds the saturating counter and `force_if` output. It is instantiated only under `MEM_ARB_STARVE_GUARD_EN`.

## Test plan
- **Lone fetch:** `if_req`=1 with addr 0x0000_0010 and a zero-wait memory returning 0x0010_0513 → `mem_req` in N+1, `if_gnt` in N+1, `if_rvalid` with data 0x0010_0513 in N+2, `stall` low in N+2.
- **Store then fetch:** `d_req`, `d_we`=1, addr 0x100, data 0xDEAD_BEEF, together with `if_req` → memory sees the write to 0x100 first. Fetch is granted in the next transaction. `d_rvalid` precedes `if_rvalid`.
- **Wait states:** `mem_gnt` delayed 3 cycles and `mem_rvalid` 2 more → `mem_req` held 4 cycles with fields stable. `stall`=1 until the `rvalid` cycle.
- **Starvation:** `d_req` held continuously with `if_req`=1.
  - Guard defined: fetch wins the 5th arbitration (`STARVE_LIMIT`=4).
  - Guard undefined: fetch is never granted.
- **Reset mid-transaction:** `rst`=0 during `WAIT_RESP` → `mem_req`, `gnt` and `rvalid` all 0 immediately. After release, a late `mem_rvalid` produces no `*_rvalid`.
- **Spurious response:** `mem_rvalid`=1 in `IDLE` → no `*_rvalid`, state unchanged.
